bcd_scan_counter: RTL
=====================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit is presented before the scan advances; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  synchronous zeroing of the count value.
REQ-005 load  input  1  synchronous parallel load strobe.
REQ-006 load_val  input  16  four BCD nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-007 count_en  input  1  increment request, sampled each cycle.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 digit_code  output  [0:3]  BCD code of the scanned digit; bit 0 is the MSB, matching the decoder input ordering.
REQ-010 digit_en  output  4  one-hot active-high digit select; bit 0 selects digit 0.
REQ-011 carry_out  output  1  one-cycle pulse on 9999->0000 wrap.
REQ-012 load_err  output  1  one-cycle pulse when a loaded nibble exceeds 9.

Function
REQ-013 Count value SHALL be four BCD digits, range 0000..9999; no digit SHALL ever hold 10..15.
REQ-014 Per-cycle priority SHALL be reset > clear > load > count_en; a lower-priority request in the same cycle SHALL be ignored, with no carry_out or load_err pulse.
REQ-015 clear=1 SHALL set the value to 0000 at the next edge.
REQ-016 load=1 SHALL write load_val at the next edge; any nibble >9 SHALL be written as 0 and load_err SHALL pulse high for exactly one cycle after that edge.
REQ-017 count_en=1 SHALL add 1 in decimal at the next edge; a digit at 9 SHALL roll to 0 and carry into the next digit.
REQ-018 Increment from 9999 SHALL produce 0000, and carry_out SHALL be high for exactly the one cycle following that edge.
REQ-019 A prescaler SHALL count 0..SCAN_DIV-1 continuously; when it is at SCAN_DIV-1, the next edge SHALL return it to 0 and advance the scan index 0->1->2->3->0.
REQ-020 With SCAN_DIV=1, the scan index SHALL advance every cycle.
REQ-021 The scanner SHALL run independently of clear, load and count_en; only reset affects it.
REQ-022 digit_code and digit_en SHALL be registered: the values after edge N SHALL reflect the scan index and count value as updated at edge N-1 (one-cycle latency).
REQ-023 digit_en SHALL be one-hot of the scan index, except that it SHALL be 0000 when blank_lz=1, the index is >0, and the indexed digit and all higher digits are 0.
REQ-024 Digit 0 SHALL never be blanked, so 0000 displays a single "0".
REQ-025 digit_code SHALL carry the indexed digit even when digit_en is blanked.

Reset
REQ-026 reset=1 SHALL set, at the next edge: value 0000, prescaler 0, scan index 0, digit_code 0000, digit_en 0001, carry_out 0, load_err 0.
REQ-027 reset asserted during an increment, load or wrap SHALL cancel it; no carry_out or load_err pulse SHALL follow.
REQ-028 All outputs SHALL be defined from the first edge with reset=1; no asynchronous paths.

Structure
REQ-029 A shared package SHALL hold the constants NUM_DIGITS=4 and BCD_MAX=9 and a 4-bit BCD digit typedef, for reuse by the decoder path.
REQ-030 Sub-module bcd_digit SHALL implement one digit register with clear, load, carry-in and carry-out (carry-out when the digit is 9 and carry-in is 1); it SHALL be instantiated 4 times in a chain.
REQ-031 Scan logic, blanking and output registers SHALL reside in bcd_scan_counter.
REQ-032 digit_code SHALL drive the seven-segment decoder input directly, with no glue logic.

Verification
REQ-033 Reset, then count_en=1 for 10 cycles -> value 0010; digit 0 code 0000, digit 1 code 0001.
REQ-034 Load 0x9999, then count_en for 1 cycle -> value 0000; carry_out high for exactly 1 cycle; no other carry_out pulses.
REQ-035 Load 0x12F4 -> value 1204; load_err pulses once. Then load with clear=1 in the same cycle -> value 0000 and no load_err pulse.
REQ-036 SCAN_DIV=3, free run from reset -> digit_en sequence 0001,0010,0100,1000, each held 3 cycles, repeating; digit_code equals the matching nibble one cycle later.
REQ-037 blank_lz=1, value 0042 -> digit_en shows 0001 and 0010, and 0000 in the slots for digits 2 and 3; value 0000 -> only 0001 is ever asserted.
REQ-038 Assert reset in the same cycle as count_en at value 9999 -> value 0000, carry_out stays 0, scan index returns to 0.

Source files
------------

// File: rtl/bcd_scan_counter_pkg.sv
// rtl/bcd_scan_counter_pkg.sv - shared BCD constants and digit type
package bcd_scan_counter_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = bcd_digit_t'(BCD_MAX);

  // True when a nibble is a legal decimal digit.
  function automatic logic bcd_valid(input bcd_digit_t d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit register with clear, load and carry chain
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       carry_i,
  output bcd_digit_t value_o,
  output logic       carry_o
);

  bcd_digit_t value_q, value_d;

  // A carry ripples onward only when this digit rolls from 9 to 0.
  assign carry_o = carry_i && (value_q == BCD_MAX_DIGIT);
  assign value_o = value_q;

  // Next digit: clear beats load beats increment; illegal loaded nibbles become 0.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      value_d = bcd_valid(load_val) ? load_val : '0;
    end else if (carry_i) begin
      value_d = (value_q == BCD_MAX_DIGIT) ? '0 : value_q + 4'd1;
    end
  end

  // Digit storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-digit BCD counter with multiplexed display scan
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        count_en,
  input  logic        blank_lz,
  output logic [0:3]  digit_code,
  output logic [3:0]  digit_en,
  output logic        carry_out,
  output logic        load_err
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  bcd_digit_t              digits [NUM_DIGITS];
  logic [NUM_DIGITS:0]     carry;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    bad_nibble;
  logic                    wrap_d, load_err_d;
  logic                    carry_q, load_err_q;
  logic [15:0]             presc_q;
  logic [1:0]              scan_idx_q;
  bcd_digit_t              code_d, code_q;
  logic [3:0]              en_d, en_q;

  assign carry[0] = count_en;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[4*i +: 4]),
      .carry_i  (carry[i]),
      .value_o  (digits[i]),
      .carry_o  (carry[i+1])
    );
  end

  // Event detection: wrap and bad load only count when not overridden by higher priority.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) bad_nibble = 1'b1;
    end
    wrap_d     = carry[NUM_DIGITS] && !clear && !load;
    load_err_d = load && !clear && bad_nibble;
  end

  // One-cycle event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Free-running prescaler and scan index; only reset touches them.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      scan_idx_q <= '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q    <= '0;
      scan_idx_q <= scan_idx_q + 2'd1;
    end else begin
      presc_q    <= presc_q + 16'd1;
    end
  end

  // Select the scanned digit and blank it when it and every higher digit are zero.
  always_comb begin
    zero_from[NUM_DIGITS-1] = (digits[NUM_DIGITS-1] == '0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (digits[i] == '0);
    end
    code_d = digits[scan_idx_q];
    en_d   = 4'b0001 << scan_idx_q;
    if (blank_lz && (scan_idx_q != 2'd0) && zero_from[scan_idx_q]) en_d = 4'b0000;
  end

  // Registered display outputs, one cycle behind scan index and count value.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
      en_q   <= 4'b0001;
    end else begin
      code_q <= code_d;
      en_q   <= en_d;
    end
  end

  assign digit_code = code_q;
  assign digit_en   = en_q;
  assign carry_out  = carry_q;
  assign load_err   = load_err_q;

endmodule
